// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: layer geometry,
// instruction-word bit positions, IDLE word and FSM state encoding.
package core_inst_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    localparam int COL          = 8;
    localparam int ROW          = 8;
    localparam int LEN_KIJ      = 9;
    localparam int LEN_NIJ      = 36;
    localparam int LEN_ONIJ     = 16;
    localparam int A_PAD_NI_DIM = 6;
    localparam int O_NI_DIM     = 4;
    localparam int KI_DIM       = 3;
    localparam int GAP_CYCLES   = 10;
    localparam int EXEC_CYCLES  = LEN_NIJ + ROW + COL;
    localparam logic [ADDR_W-1:0] W_BASE = 11'h400;

    localparam int KIJ_W = $clog2(LEN_KIJ);
    localparam int O_W   = $clog2(LEN_ONIJ);
    localparam int T_W   = $clog2(EXEC_CYCLES);

    localparam int B_ACC      = 33;
    localparam int B_CEN_PMEM = 32;
    localparam int B_WEN_PMEM = 31;
    localparam int B_A_PMEM   = 20;
    localparam int B_CEN_XMEM = 19;
    localparam int B_WEN_XMEM = 18;
    localparam int B_A_XMEM   = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXECUTE  = 1;
    localparam int B_LOAD     = 0;

    // Both memories deselected (CEN/WEN are active-low), no datapath strobes.
    localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_W_L0, S_W_LD, S_GAP, S_A_L0, S_EXEC, S_OF_RD,
        S_NEXT, S_ACC, S_ACC_T, S_ACC_G, S_FIN
    } seq_state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Controller-side bundle of the instruction sequencer: start/status handshake,
// core feedback (l0_full, ofifo_valid) and the instruction word.
interface core_inst_seq_if;
    logic                             start;
    logic                             l0_full;
    logic                             ofifo_valid;
    logic [core_inst_pkg::INST_W-1:0] inst;
    logic                             busy;
    logic                             done;
    logic                             acc_done;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]                      stall_cnt;
    logic [15:0]                      cycle_cnt;

    modport master (output start, l0_full, ofifo_valid,
                    input  inst, busy, done, acc_done, stall_cnt, cycle_cnt);
    modport slave  (input  start, l0_full, ofifo_valid,
                    output inst, busy, done, acc_done, stall_cnt, cycle_cnt);
`else
    modport master (output start, l0_full, ofifo_valid,
                    input  inst, busy, done, acc_done);
    modport slave  (input  start, l0_full, ofifo_valid,
                    output inst, busy, done, acc_done);
`endif
endinterface

// File: rtl/acc_addr_gen.sv
// pmem read address for accumulation term j of output pixel o.
// Latency: combinational. Backpressure: none.
// Arithmetic wraps modulo 2^11 like every other address in the sequencer.
module acc_addr_gen
    import core_inst_pkg::*;
(
    input  logic [O_W-1:0]    o,
    input  logic [T_W-1:0]    j,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] o_w;
    logic [ADDR_W-1:0] j_w;

    assign o_w  = ADDR_W'(o);
    assign j_w  = ADDR_W'(j);
    assign addr = (o_w / ADDR_W'(O_NI_DIM)) * ADDR_W'(A_PAD_NI_DIM) + o_w % ADDR_W'(O_NI_DIM)
                + (j_w / ADDR_W'(KI_DIM)) * ADDR_W'(A_PAD_NI_DIM) + j_w % ADDR_W'(KI_DIM)
                + j_w * ADDR_W'(LEN_NIJ);

endmodule

// File: rtl/core_inst_seq.sv
// Per-cycle core instruction sequencer for one layer; optional SEQ_PERF_CNT_EN adds stall/cycle counters.
// Latency: registered outputs, start in cycle N gives the first instruction in N+1.
// Backpressure: l0_full holds the A_L0 beat, OF_RD waits for ofifo_valid (both sampled one cycle earlier).
module core_inst_seq
    import core_inst_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.slave bus
);

    seq_state_t        state, nstate;
    logic [KIJ_W-1:0]  kij, nkij;
    logic [O_W-1:0]    o, no;
    logic [T_W-1:0]    t, nt;
    logic [T_W-1:0]    beats_done;
    logic [ADDR_W-1:0] acc_addr;
    logic [INST_W-1:0] word;

    acc_addr_gen u_acc_addr_gen (.o(no), .j(nt), .addr(acc_addr));

    // state/t describe the word currently on inst; the word for (nstate, nt) is built below.
    always_comb begin
        nstate     = state;
        nkij       = kij;
        no         = o;
        nt         = t + 1'b1;
        beats_done = t + T_W'(state == S_OF_RD ? bus.inst[B_OFIFO_RD] : bus.inst[B_L0_WR]);
        case (state)
            S_IDLE: begin
                nt = '0;
                if (bus.start) begin
                    nstate = S_W_L0;
                    nkij   = '0;
                    no     = '0;
                end
            end
            S_W_L0:  if (t == T_W'(COL - 1))        begin nstate = S_W_LD;  nt = '0; end
            S_W_LD:  if (t == T_W'(COL - 1))        begin nstate = S_GAP;   nt = '0; end
            S_GAP:   if (t == T_W'(GAP_CYCLES - 1)) begin nstate = S_A_L0;  nt = '0; end
            S_A_L0: begin
                nt = beats_done;
                if (beats_done == T_W'(LEN_NIJ)) begin nstate = S_EXEC; nt = '0; end
            end
            S_EXEC:  if (t == T_W'(EXEC_CYCLES - 1)) begin nstate = S_OF_RD; nt = '0; end
            S_OF_RD: begin
                nt = beats_done;
                if (beats_done == T_W'(LEN_NIJ)) begin nstate = S_NEXT; nt = '0; end
            end
            S_NEXT: begin
                nt = '0;
                if (kij == KIJ_W'(LEN_KIJ - 1)) begin
                    nstate = S_ACC;
                    no     = '0;
                end else begin
                    nstate = S_W_L0;
                    nkij   = kij + 1'b1;
                end
            end
            S_ACC:   if (t == T_W'(LEN_KIJ - 1)) begin nstate = S_ACC_T; nt = '0; end
            S_ACC_T: begin nstate = S_ACC_G; nt = '0; end
            S_ACC_G: begin
                nt = '0;
                if (o == O_W'(LEN_ONIJ - 1)) begin
                    nstate = S_FIN;
                end else begin
                    nstate = S_ACC;
                    no     = o + 1'b1;
                end
            end
            default: begin nstate = S_IDLE; nt = '0; end
        endcase

        word = IDLE_WORD;
        case (nstate)
            S_W_L0: begin
                word[B_CEN_XMEM]             = 1'b0;
                word[B_A_XMEM +: ADDR_W]     = W_BASE + ADDR_W'(nkij) * ADDR_W'(COL) + ADDR_W'(nt);
                word[B_L0_WR]                = 1'b1;
            end
            S_W_LD: begin
                word[B_L0_RD] = 1'b1;
                word[B_LOAD]  = 1'b1;
            end
            S_A_L0: begin
                word[B_A_XMEM +: ADDR_W] = ADDR_W'(nt);
                if (!bus.l0_full) begin
                    word[B_CEN_XMEM] = 1'b0;
                    word[B_L0_WR]    = 1'b1;
                end
            end
            S_EXEC: begin
                word[B_L0_RD]   = 1'b1;
                word[B_EXECUTE] = 1'b1;
            end
            S_OF_RD: if (bus.ofifo_valid) begin
                word[B_OFIFO_RD]         = 1'b1;
                word[B_CEN_PMEM]         = 1'b0;
                word[B_WEN_PMEM]         = 1'b0;
                word[B_A_PMEM +: ADDR_W] = ADDR_W'(kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(nt);
            end
            S_ACC: begin
                word[B_CEN_PMEM]         = 1'b0;
                word[B_A_PMEM +: ADDR_W] = acc_addr;
                word[B_ACC]              = (nt != '0);
            end
            S_ACC_T: word[B_ACC] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            kij          <= '0;
            o            <= '0;
            t            <= '0;
            bus.inst     <= IDLE_WORD;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.acc_done <= 1'b0;
        end else begin
            state        <= nstate;
            kij          <= nkij;
            o            <= no;
            t            <= nt;
            bus.inst     <= word;
            bus.busy     <= (nstate != S_IDLE) && (nstate != S_FIN);
            bus.done     <= (nstate == S_FIN);
            bus.acc_done <= (nstate == S_ACC_G);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic stall_now;
    assign stall_now = (nstate == S_A_L0 && bus.l0_full) || (nstate == S_OF_RD && !bus.ofifo_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stall_cnt <= '0;
            bus.cycle_cnt <= '0;
        end else if (state == S_IDLE && bus.start) begin
            bus.stall_cnt <= '0;
            bus.cycle_cnt <= '0;
        end else begin
            if (bus.busy && bus.cycle_cnt != 16'hFFFF) bus.cycle_cnt <= bus.cycle_cnt + 16'd1;
            if (stall_now && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end
`endif

endmodule
